// File: rtl/wmaj_pkg.sv
// Shared types and helpers for the weighted-majority trend detector:
// weight mode, per-age weight and the power-on threshold defaults.
package wmaj_pkg;

  typedef enum logic {
    WMAJ_EXP = 1'b0,
    WMAJ_LIN = 1'b1
  } wmaj_mode_e;

  // Age 0 is the newest sample and always carries the largest weight.
  function automatic int unsigned weight(wmaj_mode_e mode, int unsigned age, int unsigned depth);
    if (mode == WMAJ_EXP) begin
      return 32'd1 << (depth - 1 - age);
    end
    return depth - age;
  endfunction

  function automatic int unsigned default_thr_hi(int unsigned depth);
    return 32'd1 << (depth - 1);
  endfunction

  function automatic int unsigned default_thr_lo(int unsigned depth);
    return 32'd1 << (depth - 2);
  endfunction

endpackage

// File: rtl/wmaj_trend_array_if.sv
// Sample/result bundle of the trend array: the sampler drives the master
// side, the detector implements the slave side.
interface wmaj_trend_array_if #(
  parameter int CHANNELS = 4
);
  import wmaj_pkg::*;

  logic                in_valid;
  logic [CHANNELS-1:0] in_bits;
  wmaj_mode_e          mode;
  logic                out_valid;
  logic [CHANNELS-1:0] trend;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (
    output in_valid, in_bits, mode,
    input  out_valid, trend, rise, fall
  );

  modport slave (
    input  in_valid, in_bits, mode,
    output out_valid, trend, rise, fall
  );

endinterface

// File: rtl/wmaj_channel.sv
// One detector slice: DEPTH-bit history feeding a recency-weighted sum into
// stage 1, then hysteresis on that sum with rise/fall event pulses.
module wmaj_channel
  import wmaj_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int SUM_W = DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             sample_en,
  input  logic             in_bit,
  input  wmaj_mode_e       mode,
  input  logic             s1_valid,
  input  logic             s1_primed,
  input  logic [SUM_W-1:0] s1_thr_hi,
  input  logic [SUM_W-1:0] s1_thr_lo,
  output logic [SUM_W-1:0] s1_sum,
  output logic             trend,
  output logic             rise,
  output logic             fall
);

  logic [DEPTH-1:0] hist;
  logic [DEPTH-1:0] hist_next;
  logic [SUM_W-1:0] sum_next;

  // The sum is taken over the history as it will be after this sample,
  // so the incoming bit already counts with the newest weight.
  always_comb begin
    hist_next = {hist[DEPTH-2:0], in_bit};
    sum_next  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (hist_next[k]) begin
        sum_next = sum_next + SUM_W'(weight(mode, k, DEPTH));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist   <= '0;
      s1_sum <= '0;
      trend  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (flush) begin
      hist   <= '0;
      s1_sum <= '0;
      trend  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_en) begin
        hist   <= hist_next;
        s1_sum <= sum_next;
      end
      // Trend can only be 1 once primed, so forcing 0 while warming up never
      // needs a fall event.
      if (s1_valid) begin
        if (!s1_primed) begin
          trend <= 1'b0;
        end else if (s1_sum >= s1_thr_hi) begin
          trend <= 1'b1;
          rise  <= ~trend;
        end else if (s1_sum < s1_thr_lo) begin
          trend <= 1'b0;
          fall  <= trend;
        end
      end
    end
  end

endmodule

// File: rtl/wmaj_trend_array.sv
// Multi-channel weighted-majority trend detector: warm-up counter, threshold
// and mode registers, stage-1 sideband and debug mux around CHANNELS slices.
module wmaj_trend_array
  import wmaj_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int DEPTH    = 4,
  localparam int SUM_W    = DEPTH,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  wmaj_trend_array_if.slave bus,
  input  logic              flush,
  input  logic              cfg_we,
  input  logic [SUM_W-1:0]  cfg_hi,
  input  logic [SUM_W-1:0]  cfg_lo,
  output logic              cfg_err,
  output logic              primed,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [SUM_W-1:0]  dbg_sum
);

  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [SUM_W-1:0] THR_HI_RST = SUM_W'(default_thr_hi(DEPTH));
  localparam logic [SUM_W-1:0] THR_LO_RST = SUM_W'(default_thr_lo(DEPTH));

  logic                sample_en;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic [SUM_W-1:0]    thr_hi;
  logic [SUM_W-1:0]    thr_lo;
  logic [SUM_W-1:0]    s1_thr_hi;
  logic [SUM_W-1:0]    s1_thr_lo;
  wmaj_mode_e          mode_q;
  logic                s1_valid;
  logic                s1_primed;
  logic                out_valid_q;
  logic [SUM_W-1:0]    ch_sum [CHANNELS];
  logic [CHANNELS-1:0] trend_v;
  logic [CHANNELS-1:0] rise_v;
  logic [CHANNELS-1:0] fall_v;

  assign sample_en  = bus.in_valid & ~flush;
  assign count_next = (count == CNT_FULL) ? count : count + CNT_W'(1);
  assign primed     = (count == CNT_FULL);

  // Mode is registered alongside the thresholds, so a change presented with
  // a sample lands on the following sample. Flush leaves all of this alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_hi  <= THR_HI_RST;
      thr_lo  <= THR_LO_RST;
      mode_q  <= WMAJ_EXP;
      cfg_err <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (cfg_lo <= cfg_hi) begin
          thr_hi <= cfg_hi;
          thr_lo <= cfg_lo;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      s1_valid    <= 1'b0;
      s1_primed   <= 1'b0;
      s1_thr_hi   <= THR_HI_RST;
      s1_thr_lo   <= THR_LO_RST;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      count       <= '0;
      s1_valid    <= 1'b0;
      s1_primed   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid    <= sample_en;
      out_valid_q <= s1_valid;
      if (sample_en) begin
        count     <= count_next;
        s1_primed <= (count_next == CNT_FULL);
        s1_thr_hi <= thr_hi;
        s1_thr_lo <= thr_lo;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    wmaj_channel #(
      .DEPTH(DEPTH)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .sample_en (sample_en),
      .in_bit    (bus.in_bits[g]),
      .mode      (mode_q),
      .s1_valid  (s1_valid),
      .s1_primed (s1_primed),
      .s1_thr_hi (s1_thr_hi),
      .s1_thr_lo (s1_thr_lo),
      .s1_sum    (ch_sum[g]),
      .trend     (trend_v[g]),
      .rise      (rise_v[g]),
      .fall      (fall_v[g])
    );
  end

  // Out-of-range selects (non power-of-two CHANNELS) read as zero.
  always_comb begin
    dbg_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == dbg_sel) begin
        dbg_sum = ch_sum[i];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.trend     = trend_v;
  assign bus.rise      = rise_v;
  assign bus.fall      = fall_v;

endmodule
